// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the SPI register controller
package spi_reg_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam int FRAME_W = 16;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_PWM_DUTY  = 4;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-stage synchronizer with level and edge outputs
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Resetting to 0 keeps a low nCS at reset release looking like a frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - oversampled SPI write-frame decoder driving a five-register bank
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int MAX_ADDR    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                copi,
    input  logic                ncs,
    output logic [2*DATA_W-1:0] en_out,
    output logic [2*DATA_W-1:0] en_pwm,
    output logic [DATA_W-1:0]   pwm_duty,
    output logic                frame_ok,
    output logic                frame_err
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_W);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_W + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;
    logic ncs_level, ncs_rise, ncs_fall;
    logic unused_sync;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst(rst), .d(copi),
        .level(copi_level), .rise(copi_rise), .fall(copi_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .d(ncs),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );

    assign unused_sync = ^{sclk_level, sclk_fall, copi_rise, copi_fall};

    state_t               state, state_next;
    logic                 clr_frame, shift_en, commit;
    logic [FRAME_W-1:0]   shreg;
    logic [4:0]           bit_cnt;
    logic [DATA_W-1:0]    regs [MAX_ADDR+1];

    logic                 frame_wr;
    logic [ADDR_W-1:0]    frame_addr;
    logic [DATA_W-1:0]    frame_data;
    logic                 addr_ok;

    assign frame_wr   = shreg[FRAME_W-1];
    assign frame_addr = shreg[FRAME_W-2 -: ADDR_W];
    assign frame_data = shreg[DATA_W-1:0];
    assign addr_ok    = (frame_addr <= ADDR_W'(MAX_ADDR));

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_next;
    end

    // An nCS rise takes priority over a coincident SCLK rise, so that edge is never counted.
    always_comb begin
        state_next = state;
        clr_frame  = 1'b0;
        shift_en   = 1'b0;
        commit     = 1'b0;
        case (state)
            WAIT_IDLE: if (ncs_level) state_next = IDLE;
            IDLE: begin
                if (ncs_fall) begin
                    clr_frame  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise)       state_next = COMMIT;
                else if (sclk_rise) shift_en   = 1'b1;
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i <= MAX_ADDR; i++) regs[i] <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (clr_frame) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg <= {shreg[FRAME_W-2:0], copi_level};
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
            end
            if (commit) begin
                if (bit_cnt == CNT_FULL && frame_wr && addr_ok) begin
                    for (int i = 0; i <= MAX_ADDR; i++)
                        if (frame_addr == ADDR_W'(i)) regs[i] <= frame_data;
                    frame_ok <= 1'b1;
                end else if (!(bit_cnt == CNT_FULL && !frame_wr)) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign en_out   = {regs[ADDR_EN_OUT_HI], regs[ADDR_EN_OUT_LO]};
    assign en_pwm   = {regs[ADDR_EN_PWM_HI], regs[ADDR_EN_PWM_LO]};
    assign pwm_duty = regs[ADDR_PWM_DUTY];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - table-driven self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

    localparam int SYNC = 2;
    localparam int H    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        copi = 1'b0;
    logic        ncs = 1'b1;
    logic [15:0] en_out, en_pwm;
    logic [7:0]  pwm_duty;
    logic        frame_ok, frame_err;

    spi_reg_ctrl #(.SYNC_STAGES(SYNC), .ADDR_W(7), .DATA_W(8), .MAX_ADDR(4)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_out(en_out), .en_pwm(en_pwm), .pwm_duty(pwm_duty),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int ok_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
    end

    int n_pass = 0;
    int n_total = 0;
    int ok_base = 0;
    int err_base = 0;

    typedef struct {
        int          nbits;
        logic [16:0] frame;
        int          gap;
        bit          check;
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        int          ok;
        int          err;
    } vec_t;

    vec_t vecs[10];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic shift_bits(input logic [16:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            copi = v[i];
            cyc(H);
            sclk = 1'b1;
            cyc(H);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [16:0] v, input int nbits, input int gap);
        ncs = 1'b0;
        cyc(H);
        shift_bits(v, nbits - 1, 0);
        cyc(H);
        ncs = 1'b1;
        cyc(gap);
    endtask

    task automatic check_all(input string tag, input logic [15:0] eo, input logic [15:0] ep,
                             input logic [7:0] ed, input int eok, input int eerr);
        chk({tag, " en_out"}, 32'(en_out), 32'(eo));
        chk({tag, " en_pwm"}, 32'(en_pwm), 32'(ep));
        chk({tag, " pwm_duty"}, 32'(pwm_duty), 32'(ed));
        chk({tag, " ok_pulses"}, 32'(ok_cnt - ok_base), 32'(eok));
        chk({tag, " err_pulses"}, 32'(err_cnt - err_base), 32'(eerr));
        ok_base  = ok_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        int lat;
        bit seen;

        vecs[0] = '{16, 17'h080F0, 10, 1'b1, 16'h00F0, 16'h0000, 8'h00, 1, 0};
        vecs[1] = '{16, 17'h08401, SYNC + 2, 1'b0, 16'h0, 16'h0, 8'h0, 0, 0};
        vecs[2] = '{16, 17'h08180, 10, 1'b1, 16'h80F0, 16'h0000, 8'h01, 2, 0};
        vecs[3] = '{16, 17'h08555, 10, 1'b1, 16'h80F0, 16'h0000, 8'h01, 0, 1};
        vecs[4] = '{16, 17'h00012, 10, 1'b1, 16'h80F0, 16'h0000, 8'h01, 0, 0};
        vecs[5] = '{12, 17'h008FF, 10, 1'b1, 16'h80F0, 16'h0000, 8'h01, 0, 1};
        vecs[6] = '{17, 17'h180FF, 10, 1'b1, 16'h80F0, 16'h0000, 8'h01, 0, 1};
        vecs[7] = '{16, 17'h08233, 10, 1'b1, 16'h80F0, 16'h0033, 8'h01, 1, 0};
        vecs[8] = '{16, 17'h083C3, 10, 1'b1, 16'h80F0, 16'hC333, 8'h01, 1, 0};
        vecs[9] = '{0,  17'h00000, 10, 1'b1, 16'h80F0, 16'hC333, 8'h01, 0, 1};

        cyc(3);
        check_all("reset", 16'h0, 16'h0, 8'h0, 0, 0);
        chk("reset frame_ok", 32'(frame_ok), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        cyc(6);

        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].frame, vecs[v].nbits, vecs[v].gap);
            if (vecs[v].check)
                check_all($sformatf("vec%0d", v), vecs[v].en_out, vecs[v].en_pwm,
                          vecs[v].duty, vecs[v].ok, vecs[v].err);
        end

        // 16th SCLK rise coincides with the nCS rise: only 15 bits count
        ncs = 1'b0;
        cyc(H);
        shift_bits(17'h08077, 15, 1);
        copi = 1'b1;
        cyc(H);
        sclk = 1'b1;
        ncs  = 1'b1;
        cyc(H);
        sclk = 1'b0;
        cyc(10);
        check_all("simul_edge", 16'h80F0, 16'hC333, 8'h01, 0, 1);

        // pin-to-pulse latency after the nCS rise
        ncs = 1'b0;
        cyc(H);
        shift_bits(17'h08011, 15, 0);
        cyc(H);
        ncs  = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            cyc(1);
            if (frame_ok) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk("latency_seen", 32'(seen), 32'd1);
        chk("latency_bound", 32'(seen && lat >= 2 && lat <= SYNC + 3), 32'd1);
        cyc(10);
        check_all("latency_frame", 16'h8011, 16'hC333, 8'h01, 1, 0);

        // reset in the middle of a frame; the tail must not be accepted
        ncs = 1'b0;
        cyc(H);
        shift_bits(17'h082AA, 15, 8);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        shift_bits(17'h082AA, 7, 0);
        cyc(H);
        ncs = 1'b1;
        cyc(10);
        check_all("mid_reset", 16'h0, 16'h0, 8'h0, 0, 0);

        send_frame(17'h082AA, 16, 10);
        check_all("after_reset", 16'h0, 16'h00AA, 8'h0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
